voice_frame_unpack: RTL and testbench

VOICE_FRAME_UNPACK -- requirements
Module: voice_frame_unpack

---
 rtl/voice_frame_unpack.sv | 155 +++++++++++++++
 tb/tb_voice_frame_unpack.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/voice_frame_unpack.sv
// Byte-stream voice frame parser: finds the start marker, pairs payload bytes
// into 16-bit samples, and validates the end marker before counting the frame.
module voice_frame_unpack #(
  parameter int         PAYLOAD_BYTES = 2048,
  parameter logic [7:0] SOF_B1        = 8'hFF,
  parameter logic [7:0] SOF_B2        = 8'hB3,
  parameter logic [7:0] EOF_B1        = 8'hFF,
  parameter logic [7:0] EOF_B2        = 8'hB4
) (
  input  logic        sck,
  input  logic        rst,
  input  logic        voice_vsync,
  input  logic        voice_href,
  input  logic [7:0]  data_in,
  output logic [15:0] sample_out,
  output logic        sample_valid,
  output logic        frame_start,
  output logic        frame_done,
  output logic        frame_err,
  output logic [15:0] frame_cnt,
  output logic [2:0]  state_dbg
);

  localparam int            CW       = $clog2(PAYLOAD_BYTES);
  localparam logic [CW-1:0] LAST_POS = CW'(PAYLOAD_BYTES - 1);

  typedef enum logic [2:0] {
    HUNT    = 3'd0,
    SOF2    = 3'd1,
    PAYLOAD = 3'd2,
    EOF1    = 3'd3,
    EOF2    = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] pos_q, pos_d;
  logic [7:0]    hi_q, hi_d;
  logic [15:0]   sample_q, sample_d;
  logic          valid_q, valid_d;
  logic          start_q, start_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [15:0]   fcnt_q, fcnt_d;

  logic is_byte;
  logic in_frame;

  // vsync outranks href: a cycle with both high is a gap, never a byte.
  assign is_byte  = voice_href & ~voice_vsync;
  assign in_frame = (state_q == PAYLOAD) || (state_q == EOF1) || (state_q == EOF2);

  always_comb begin
    state_d  = state_q;
    pos_d    = pos_q;
    hi_d     = hi_q;
    sample_d = sample_q;
    fcnt_d   = fcnt_q;
    valid_d  = 1'b0;
    start_d  = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;

    if (voice_vsync) begin
      // Abort is reported only if a frame was actually open.
      err_d   = in_frame;
      state_d = HUNT;
      pos_d   = '0;
      hi_d    = 8'h00;
    end else if (is_byte) begin
      unique case (state_q)
        HUNT: begin
          if (data_in == SOF_B1) state_d = SOF2;
        end
        SOF2: begin
          if (data_in == SOF_B2) begin
            state_d = PAYLOAD;
            start_d = 1'b1;
            pos_d   = '0;
            hi_d    = 8'h00;
          end else if (data_in == SOF_B1) begin
            state_d = SOF2;
          end else begin
            state_d = HUNT;
          end
        end
        PAYLOAD: begin
          // Pairing follows the payload position, so marker values are plain data here.
          if (!pos_q[0]) begin
            hi_d = data_in;
          end else begin
            sample_d = {hi_q, data_in};
            valid_d  = 1'b1;
          end
          if (pos_q == LAST_POS) begin
            state_d = EOF1;
            pos_d   = '0;
          end else begin
            pos_d = pos_q + CW'(1);
          end
        end
        EOF1: begin
          if (data_in == EOF_B1) begin
            state_d = EOF2;
          end else begin
            err_d   = 1'b1;
            state_d = HUNT;
          end
        end
        EOF2: begin
          state_d = HUNT;
          if (data_in == EOF_B2) begin
            done_d = 1'b1;
            fcnt_d = fcnt_q + 16'd1;
          end else begin
            err_d = 1'b1;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge sck or negedge rst) begin
    if (!rst) begin
      state_q  <= HUNT;
      pos_q    <= '0;
      hi_q     <= 8'h00;
      sample_q <= 16'h0000;
      valid_q  <= 1'b0;
      start_q  <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      fcnt_q   <= 16'h0000;
    end else begin
      state_q  <= state_d;
      pos_q    <= pos_d;
      hi_q     <= hi_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
      start_q  <= start_d;
      done_q   <= done_d;
      err_q    <= err_d;
      fcnt_q   <= fcnt_d;
    end
  end

  assign sample_out   = sample_q;
  assign sample_valid = valid_q;
  assign frame_start  = start_q;
  assign frame_done   = done_q;
  assign frame_err    = err_q;
  assign frame_cnt    = fcnt_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_voice_frame_unpack.sv
// Directed bench for voice_frame_unpack: drives framed byte streams and checks
// samples through an expected queue plus per-frame pulse counts.
module tb_voice_frame_unpack;

  localparam int PB = 2048;

  logic        sck = 1'b0;
  logic        rst = 1'b0;
  logic        voice_vsync = 1'b0;
  logic        voice_href = 1'b0;
  logic [7:0]  data_in = 8'h00;
  logic [15:0] sample_out;
  logic        sample_valid;
  logic        frame_start;
  logic        frame_done;
  logic        frame_err;
  logic [15:0] frame_cnt;
  logic [2:0]  state_dbg;

  voice_frame_unpack #(.PAYLOAD_BYTES(PB)) dut (
    .sck          (sck),
    .rst          (rst),
    .voice_vsync  (voice_vsync),
    .voice_href   (voice_href),
    .data_in      (data_in),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .frame_start  (frame_start),
    .frame_done   (frame_done),
    .frame_err    (frame_err),
    .frame_cnt    (frame_cnt),
    .state_dbg    (state_dbg)
  );

  // ---------------- clock ----------------
  always #5 sck = ~sck;

  // ---------------- scoreboard state ----------------
  logic [15:0] exp_q[$];
  logic [7:0]  pl [PB];
  int          n_chk = 0;
  int          n_err = 0;
  int          n_start = 0;
  int          n_done = 0;
  int          n_ferr = 0;
  int          n_samp = 0;
  logic        lo_drv = 1'b0;
  logic        lo_seen = 1'b0;
  logic [15:0] last_sample = 16'h0000;
  logic [15:0] mon_cnt = 16'h0000;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  always @(posedge sck) lo_seen <= lo_drv;

  always @(negedge sck) begin
    logic [15:0] e;
    if (!rst) begin
      last_sample = 16'h0000;
      mon_cnt     = 16'h0000;
    end else begin
      if (sample_valid || lo_seen) check("valid_timing", {31'd0, sample_valid}, {31'd0, lo_seen});
      if (sample_valid) begin
        n_samp++;
        if (exp_q.size() == 0) begin
          check("extra_sample", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          check("sample", {16'd0, sample_out}, {16'd0, e});
        end
        last_sample = sample_out;
      end else if (sample_out !== last_sample) begin
        check("sample_hold", {16'd0, sample_out}, {16'd0, last_sample});
      end
      if (frame_start) n_start++;
      if (frame_err) n_ferr++;
      if (frame_done) begin
        n_done++;
        mon_cnt = mon_cnt + 16'd1;
        check("cnt_at_done", {16'd0, frame_cnt}, {16'd0, mon_cnt});
      end
      if (frame_done && frame_err) check("done_err_excl", {30'd0, frame_done, frame_err}, 32'd2);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge sck); #1;
      voice_href  = 1'b0;
      voice_vsync = 1'b0;
      lo_drv      = 1'b0;
      data_in     = 8'(($urandom_range(0, 255)));
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic lo, input int gap);
    @(posedge sck); #1;
    voice_href  = 1'b1;
    voice_vsync = 1'b0;
    data_in     = b;
    lo_drv      = lo;
    if (gap > 0) idle(gap);
  endtask

  task automatic pulse_vsync();
    @(posedge sck); #1;
    voice_vsync = 1'b1;
    voice_href  = 1'b1;
    data_in     = 8'hB4;
    lo_drv      = 1'b0;
    @(posedge sck); #1;
    voice_vsync = 1'b0;
    voice_href  = 1'b0;
  endtask

  task automatic fill_ramp();
    for (int i = 0; i < PB; i++) pl[i] = 8'(i);
  endtask

  // Sends the start marker and n_pay payload bytes; a full payload gets FF + eof2.
  task automatic send_frame(input int gap, input logic [7:0] eof2, input int n_pay);
    send_byte(8'hFF, 1'b0, gap);
    send_byte(8'hB3, 1'b0, gap);
    for (int i = 0; i < n_pay; i++) begin
      if (i % 2 == 1) exp_q.push_back({pl[i-1], pl[i]});
      send_byte(pl[i], (i % 2 == 1), gap);
    end
    if (n_pay == PB) begin
      send_byte(8'hFF, 1'b0, gap);
      send_byte(eof2, 1'b0, gap);
    end
  endtask

  task automatic clear_counts();
    n_start = 0;
    n_done  = 0;
    n_ferr  = 0;
    n_samp  = 0;
  endtask

  task automatic frame_checks(input string tag, input int st, input int samp, input int dn,
                              input int er, input int cnt);
    check({tag, "_start"}, n_start, st);
    check({tag, "_samples"}, n_samp, samp);
    check({tag, "_done"}, n_done, dn);
    check({tag, "_err"}, n_ferr, er);
    check({tag, "_frame_cnt"}, {16'd0, frame_cnt}, cnt);
    check({tag, "_queue_empty"}, exp_q.size(), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_sample_out"}, {16'd0, sample_out}, 0);
    check({tag, "_sample_valid"}, {31'd0, sample_valid}, 0);
    check({tag, "_frame_start"}, {31'd0, frame_start}, 0);
    check({tag, "_frame_done"}, {31'd0, frame_done}, 0);
    check({tag, "_frame_err"}, {31'd0, frame_err}, 0);
    check({tag, "_frame_cnt"}, {16'd0, frame_cnt}, 0);
    check({tag, "_state"}, {29'd0, state_dbg}, 0);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    // Reset state
    repeat (3) @(posedge sck);
    @(negedge sck);
    check_all_zero("reset");
    @(posedge sck); #1;
    rst = 1'b1;
    idle(3);

    // Good frame, ramp payload
    fill_ramp();
    clear_counts();
    send_frame(0, 8'hB4, PB);
    idle(4);
    frame_checks("good", 1, 1024, 1, 0, 1);
    check("good_last_sample", {16'd0, sample_out}, 32'h0000FEFF);

    // Same frame with 3-cycle href gaps after every byte
    clear_counts();
    send_frame(3, 8'hB4, PB);
    idle(4);
    frame_checks("gaps", 1, 1024, 1, 0, 2);

    // Marker values inside the payload are data
    pl[10] = 8'hFF; pl[11] = 8'hB4;
    pl[20] = 8'hFF; pl[21] = 8'hB3;
    clear_counts();
    send_frame(0, 8'hB4, PB);
    idle(4);
    frame_checks("markers", 1, 1024, 1, 0, 3);
    fill_ramp();

    // Bad end marker, then a good frame
    clear_counts();
    send_frame(0, 8'hB5, PB);
    idle(4);
    frame_checks("bad_eof", 1, 1024, 0, 1, 3);
    clear_counts();
    send_frame(0, 8'hB4, PB);
    idle(4);
    frame_checks("after_bad", 1, 1024, 1, 0, 4);

    // vsync after 101 payload bytes, then garbage and FF FF B3
    clear_counts();
    send_frame(0, 8'hB4, 101);
    pulse_vsync();
    idle(4);
    frame_checks("vsync", 1, 50, 0, 1, 4);
    clear_counts();
    send_byte(8'h12, 1'b0, 0);
    send_byte(8'h34, 1'b0, 0);
    send_byte(8'hFF, 1'b0, 0);
    send_frame(0, 8'hB4, PB);
    idle(4);
    frame_checks("resync", 1, 1024, 1, 0, 5);

    // Reset mid-frame after 500 payload bytes
    clear_counts();
    send_frame(0, 8'hB4, 500);
    idle(2);
    check("rst_pre_samples", n_samp, 250);
    check("rst_pre_queue", exp_q.size(), 0);
    @(posedge sck); #3;
    rst = 1'b0;
    #1;
    check_all_zero("midreset");
    idle(3);
    check("midreset_no_err", n_ferr, 0);
    @(posedge sck); #1;
    rst = 1'b1;
    clear_counts();
    send_frame(0, 8'hB4, PB);
    idle(4);
    frame_checks("post_reset", 1, 1024, 1, 0, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
